// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional MULDIV_EARLY_OUT_EN resolves trivial operand cases without entering CALC.
module muldiv_unit (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [2:0]  md_op_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] md_data_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } md_op_t;

  state_t      state, state_next;
  md_op_t      op_q, op_in;
  logic        sign_q, div_zero_q;
  logic [4:0]  cnt_q;
  logic [31:0] b_mag_q;
  logic [31:0] hi_q, lo_q;

  logic        accept, a_signed, b_signed, sign_in, early;
  logic [31:0] a_mag, b_mag;

  assign op_in  = md_op_t'(md_op_i);
  assign accept = start_i && (state == IDLE || state == DONE);

  always_comb begin
    // NOTE: defaults first so every path assigns both flags and no latch is inferred.
    a_signed = 1'b1;
    b_signed = 1'b1;
    case (op_in)
      OP_MULHSU:                   b_signed = 1'b0;
      OP_MULHU, OP_DIVU, OP_REMU: begin
        a_signed = 1'b0;
        b_signed = 1'b0;
      end
      default: ;
    endcase
  end

  assign a_mag   = (a_signed && operand_a_i[31]) ? -operand_a_i : operand_a_i;
  assign b_mag   = (b_signed && operand_b_i[31]) ? -operand_b_i : operand_b_i;
  // Remainders take the dividend's sign; products and quotients the xor of both.
  assign sign_in = (op_in == OP_REM || op_in == OP_REMU)
                 ? (a_signed && operand_a_i[31])
                 : ((a_signed && operand_a_i[31]) ^ (b_signed && operand_b_i[31]));

`ifdef MULDIV_EARLY_OUT_EN
  logic [31:0] early_result;

  always_comb begin
    early        = 1'b0;
    early_result = 32'd0;
    if (!md_op_i[2]) begin
      early = (operand_a_i == 32'd0) || (operand_b_i == 32'd0);
    end else if (operand_b_i == 32'd0) begin
      early        = 1'b1;
      early_result = md_op_i[1] ? operand_a_i : 32'hFFFF_FFFF;
    end else if ((op_in == OP_DIV || op_in == OP_REM) &&
                 operand_a_i == 32'h8000_0000 && operand_b_i == 32'hFFFF_FFFF) begin
      early        = 1'b1;
      early_result = md_op_i[1] ? 32'd0 : 32'h8000_0000;
    end
  end
`else
  assign early = 1'b0;
`endif

  // One iteration step, shared register pair: {hi,lo} is the product or {rem,quo}.
  logic [32:0] mul_sum, div_shift, div_diff;
  logic        div_ge;
  logic [63:0] mul_next, mul_signed;
  logic [31:0] rem_next, quo_next, div_pick, final_result;

  assign mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_mag_q} : 33'd0);
  assign mul_next   = {mul_sum, lo_q[31:1]};
  assign mul_signed = sign_q ? -mul_next : mul_next;

  assign div_shift  = {hi_q, lo_q[31]};
  assign div_diff   = div_shift - {1'b0, b_mag_q};
  assign div_ge     = div_shift >= {1'b0, b_mag_q};
  assign rem_next   = div_ge ? div_diff[31:0] : div_shift[31:0];
  assign quo_next   = {lo_q[30:0], div_ge};
  assign div_pick   = op_q[1] ? rem_next : quo_next;

  always_comb begin
    final_result = 32'd0;
    if (!op_q[2]) begin
      final_result = (op_q == OP_MUL) ? mul_signed[31:0] : mul_signed[63:32];
    end else if (div_zero_q && !op_q[1]) begin
      final_result = 32'hFFFF_FFFF;
    end else begin
      final_result = sign_q ? -div_pick : div_pick;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = early ? DONE : CALC;
      CALC:    if (cnt_q == 5'd31) state_next = DONE;
      DONE:    state_next = accept ? (early ? DONE : CALC) : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state == CALC);
    valid_o = (state == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q       <= OP_MUL;
      sign_q     <= 1'b0;
      div_zero_q <= 1'b0;
      cnt_q      <= 5'd0;
      b_mag_q    <= 32'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      md_data_o  <= 32'd0;
    end else if (accept) begin
      // NOTE: non-blocking so every register samples pre-edge values of its sources.
      op_q       <= op_in;
      sign_q     <= sign_in;
      div_zero_q <= (operand_b_i == 32'd0);
      cnt_q      <= 5'd0;
      b_mag_q    <= b_mag;
      hi_q       <= 32'd0;
      lo_q       <= a_mag;
`ifdef MULDIV_EARLY_OUT_EN
      if (early) md_data_o <= early_result;
`endif
    end else if (state == CALC) begin
      cnt_q <= cnt_q + 5'd1;
      if (!op_q[2]) begin
        hi_q <= mul_next[63:32];
        lo_q <= mul_next[31:0];
      end else begin
        hi_q <= rem_next;
        lo_q <= quo_next;
      end
      if (cnt_q == 5'd31) md_data_o <= final_result;
    end
  end

endmodule
